weight_bram_reader: RTL and testbench
=====================================

# weight_bram_reader

Read-side sequencer for one per-neuron weight BRAM (DEPTH x 16-bit, synchronous read on the falling clock edge). On a START pulse it issues a burst of reads over a contiguous address window, captures the read data and presents each weight to the downstream MAC stage over a valid/ready stream. It sits between a weight BRAM and the neuron accumulator and never writes the BRAM.

## Interface
- DEPTH, 28, number of words in the attached BRAM.
- ADDR_W, 5, BRAM address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 16, weight width.

- CLK  in  1  single clock; all registers update on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle request pulse; ignored while BUSY=1.
- START_ADDR  in  ADDR_W  first BRAM address, sampled with START.
- LENGTH  in  ADDR_W+1  number of words to read, sampled with START.
- BUSY  out  1  high from the cycle after an accepted START until the cycle DONE pulses.
- DONE  out  1  one-cycle pulse when the burst is complete.
- BRAM_ADDR  out  ADDR_W  registered read address.
- BRAM_EN  out  1  registered read enable.
- BRAM_WE  out  1  constant 0.
- BRAM_DI  out  DATA_W  constant 0.
- BRAM_DO  in  DATA_W  BRAM read data.
- W_DATA  out  DATA_W  weight to consumer (FIFO head).
- W_VALID  out  1  W_DATA holds a valid weight.
- W_READY  in  1  consumer accepts the weight when W_VALID and W_READY are both high.
- W_LAST  out  1  high with the final weight of the burst.

## Operation
- Reset values: BUSY=0, DONE=0, BRAM_EN=0, BRAM_ADDR=0, W_VALID=0, W_LAST=0, W_DATA=0. FIFO is emptied and all counters cleared. Reset is asynchronous: BRAM_EN drops immediately, even mid-burst.
- States:
  - IDLE: START=1 latches the request.
    - Effective length L = min(LENGTH, DEPTH - START_ADDR).
    - START_ADDR >= DEPTH gives L=0.
    - L=0 goes to FINISH with no BRAM access.
    - Otherwise go to RUN.
  - RUN: issue reads and drain the FIFO. Go to FINISH on the handshake of the word carrying W_LAST.
  - FINISH: DONE=1 for one cycle, then IDLE.
- Issue counter: counts 0..L-1. BRAM_ADDR = START_ADDR + issue count, with no wrap past DEPTH-1 (guaranteed by clamping L).
- Output FIFO: 2 entries.
  - Inflight flag: set for the cycle BRAM_EN=1.
  - Issue condition: remaining > 0 and (fifo_count + inflight - pop) < 2, where pop = W_VALID & W_READY in the current cycle.
  - This sustains one word per cycle while W_READY is held high.
- Capture: BRAM_DO is written into the FIFO on the posedge following the cycle in which BRAM_EN=1. The BRAM samples ADDR/EN on the intervening negedge.
- Write-through: when the FIFO is empty, the captured word appears as W_DATA/W_VALID on the capture edge.
- W_LAST: tagged on the L-th captured word.
- Handshake rules:
  - W_DATA and W_LAST stay stable while W_VALID=1 and W_READY=0.
  - W_VALID never drops without a handshake.
- START during BUSY or FINISH: ignored, with no effect on the current burst.
- BRAM_WE and BRAM_DI are 0 at all times.

## Timing
- START sampled at edge 0.
  - Edge 1: BUSY=1, BRAM_EN=1, BRAM_ADDR=START_ADDR.
  - Edge 2: first word is W_VALID.
  - Start-to-first-data latency is 2 cycles.
- With W_READY held at 1: one word per cycle. The last word is valid at edge L+1 and DONE pulses at edge L+2. Total is L+2 cycles from START to DONE.
- Backpressure: with W_READY=0 and the FIFO full, BRAM_EN=0. Issue resumes in the same cycle that a pop occurs.
- L=0: BUSY=1 at edge 1, DONE=1 and BUSY=0 at edge 2, with no BRAM_EN and no W_VALID.
- DONE and W_VALID are never high in the same cycle.

## Test plan
- Reset, then START with START_ADDR=0, LENGTH=28, W_READY=1 -> 28 weights matching the BRAM contents for addresses 0..27 in order, on consecutive cycles starting 2 cycles after START. W_LAST only on word 27. DONE at cycle 30.
- START_ADDR=20, LENGTH=16 -> clamped to 8 words (addresses 20..27). W_LAST on address 27 and no BRAM_ADDR above 27.
- START_ADDR=3, LENGTH=6, with W_READY toggling 1,0,0,1,0,1... -> all 6 words delivered in order with no loss or duplication. W_DATA is stable while stalled. BRAM_EN stays low whenever the FIFO is full with nothing popped.
- LENGTH=0, and separately START_ADDR=30 -> DONE two cycles after START. BRAM_EN and W_VALID never asserted.
- A second START pulse mid-burst -> ignored and the burst completes unchanged. RST_N driven low mid-burst -> BRAM_EN, W_VALID and BUSY go to 0 immediately. After release, a new START produces a clean burst from its own START_ADDR.

Source files
------------

// File: rtl/weight_bram_reader_if.sv
// -----------------------------------------------------------------------------
// weight_bram_reader_if
//
// Weight stream from the BRAM reader to the downstream MAC stage.
//
// Signals:
//   data   weight at the head of the reader's output FIFO
//   valid  data holds a valid weight
//   ready  consumer accepts the weight when valid and ready are both high
//   last   marks the final weight of a burst (qualified by valid)
//
// Modports:
//   master  producer side (the reader)
//   slave   consumer side (the MAC / accumulator)
// -----------------------------------------------------------------------------
interface weight_bram_reader_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/weight_bram_reader.sv
// -----------------------------------------------------------------------------
// weight_bram_reader
//
// Read-side sequencer for one per-neuron weight BRAM. A start pulse launches a
// burst of reads over a contiguous address window (clamped to the end of the
// BRAM); each returned word goes through a 2-entry FIFO onto a valid/ready
// weight stream. The BRAM is never written.
//
// Ports:
//   clk         clock, all registers update on posedge
//   rst_n       asynchronous active-low reset
//   start       one-cycle request pulse, ignored unless idle
//   start_addr  first BRAM address, sampled with start
//   length      requested word count, sampled with start
//   busy        high while a burst is in progress
//   done        one-cycle pulse when the burst is complete
//   bram_addr   registered BRAM read address
//   bram_en     registered BRAM read enable
//   bram_we     BRAM write enable, tied low
//   bram_di     BRAM write data, tied low
//   bram_do     BRAM read data (BRAM reads on the falling edge)
//   w           weight stream (master side)
// -----------------------------------------------------------------------------
module weight_bram_reader #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic                bram_en,
    output logic                bram_we,
    output logic [DATA_W-1:0]   bram_di,
    input  logic [DATA_W-1:0]   bram_do,
    weight_bram_reader_if.master w
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO    = '0;
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Burst bookkeeping
    logic [ADDR_W-1:0] base_addr_reg;
    logic [ADDR_W:0]   issue_cnt_reg;
    logic [ADDR_W:0]   remaining_reg;
    logic              zero_len_reg;

    // Read port registers; bram_en_reg doubles as the inflight flag
    logic              bram_en_reg;
    logic [ADDR_W-1:0] bram_addr_reg;
    logic              inflight_last_reg;

    // Output FIFO, slot 0 is the head
    logic [DATA_W-1:0] slot_data_reg [2];
    logic              slot_last_reg [2];
    logic [DATA_W-1:0] slot_data_next [2];
    logic              slot_last_next [2];
    logic [1:0]        fifo_count_reg;
    logic [1:0]        fifo_count_next;

    // Combinational helpers
    logic [ADDR_W:0]   start_ext;
    logic [ADDR_W:0]   room;
    logic [ADDR_W:0]   eff_len;
    logic              accept;
    logic              head_valid;
    logic              head_last;
    logic              pop;
    logic [2:0]        occ_after;
    logic [1:0]        cnt_after_pop;
    logic              issue;
    logic              issue_last;
    logic [ADDR_W-1:0] issue_addr;

    // ------------------------------------------------------------------
    // Request decode: clamp the window so it never runs past DEPTH-1
    // ------------------------------------------------------------------
    assign start_ext = {1'b0, start_addr};
    assign room      = DEPTH_W - start_ext;

    always_comb begin
        eff_len = ZERO;
        if (start_ext < DEPTH_W) begin
            eff_len = (length < room) ? length : room;
        end
    end

    assign accept = (state_reg == IDLE) && start;

    // ------------------------------------------------------------------
    // FIFO status and stream outputs
    // ------------------------------------------------------------------
    assign head_valid = (fifo_count_reg != 2'd0);
    assign head_last  = head_valid && slot_last_reg[0];
    assign pop        = head_valid && w.ready;

    assign w.data  = slot_data_reg[0];
    assign w.valid = head_valid;
    assign w.last  = head_last;

    // Occupancy as it will stand after this cycle's capture and pop; a new
    // read is only issued if its word is guaranteed a free slot.
    assign occ_after = {1'b0, fifo_count_reg} + {2'b00, bram_en_reg} - {2'b00, pop};

    // ------------------------------------------------------------------
    // Read issue
    // ------------------------------------------------------------------
    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = base_addr_reg + issue_cnt_reg[ADDR_W-1:0];
        if (accept) begin
            // First read goes out on the same edge that accepts the request
            issue      = (eff_len != ZERO);
            issue_last = (eff_len == ONE);
            issue_addr = start_addr;
        end else if (state_reg == RUN) begin
            issue      = (remaining_reg != ZERO) && (occ_after < 3'd2);
            issue_last = (remaining_reg == ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_addr_reg     <= '0;
            issue_cnt_reg     <= '0;
            remaining_reg     <= '0;
            zero_len_reg      <= 1'b0;
            bram_en_reg       <= 1'b0;
            bram_addr_reg     <= '0;
            inflight_last_reg <= 1'b0;
        end else begin
            bram_en_reg       <= issue;
            inflight_last_reg <= issue && issue_last;
            if (issue) begin
                bram_addr_reg <= issue_addr;
            end
            if (accept) begin
                base_addr_reg <= start_addr;
                zero_len_reg  <= (eff_len == ZERO);
                issue_cnt_reg <= issue ? ONE : ZERO;
                remaining_reg <= eff_len - (issue ? ONE : ZERO);
            end else if (issue) begin
                issue_cnt_reg <= issue_cnt_reg + ONE;
                remaining_reg <= remaining_reg - ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: pop shifts slot 1 into the head, the captured word lands
    // in the first free slot. When empty the capture goes straight to the
    // head, so the word is visible on the capture edge.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_data_next[i] = slot_data_reg[i];
            slot_last_next[i] = slot_last_reg[i];
        end
        cnt_after_pop = fifo_count_reg - {1'b0, pop};
        if (pop) begin
            slot_data_next[0] = slot_data_reg[1];
            slot_last_next[0] = slot_last_reg[1];
        end
        // Issue gating keeps cnt_after_pop at 0 or 1 whenever a word arrives
        if (bram_en_reg) begin
            slot_data_next[cnt_after_pop[0]] = bram_do;
            slot_last_next[cnt_after_pop[0]] = inflight_last_reg;
        end
        fifo_count_next = cnt_after_pop + {1'b0, bram_en_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_data_reg[i] <= '0;
                slot_last_reg[i] <= 1'b0;
            end
            fifo_count_reg <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                slot_data_reg[i] <= slot_data_next[i];
                slot_last_reg[i] <= slot_last_next[i];
            end
            fifo_count_reg <= fifo_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A zero-length request still spends one cycle in RUN so that busy is
    // seen for a cycle and done lands two cycles after start, matching the
    // timing of a real burst.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((pop && head_last) || zero_len_reg) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == FINISH);
    assign bram_en   = bram_en_reg;
    assign bram_addr = bram_addr_reg;
    assign bram_we   = 1'b0;
    assign bram_di   = '0;

endmodule

// File: tb/tb_weight_bram_reader.sv
// -----------------------------------------------------------------------------
// tb_weight_bram_reader
//
// Bench for weight_bram_reader: a behavioural falling-edge BRAM, randomized
// contents and backpressure, and an expected word list derived from the
// clamped request window.
// -----------------------------------------------------------------------------
module tb_weight_bram_reader;

    localparam int DEPTH  = 28;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [DATA_W-1:0] bram_di;
    logic [DATA_W-1:0] bram_do = '0;

    logic [DATA_W-1:0] mem [DEPTH];

    int tests_run    = 0;
    int tests_failed = 0;

    weight_bram_reader_if #(.DATA_W(DATA_W)) w_if ();

    always #5 clk = ~clk;

    weight_bram_reader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_di    (bram_di),
        .bram_do    (bram_do),
        .w          (w_if)
    );

    // Weight BRAM: synchronous read on the falling edge
    always @(negedge clk) begin
        if (bram_en === 1'b1) begin
            bram_do <= mem[bram_addr];
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_W'($urandom);
        end
    endtask

    // Runs one burst from the current point (just after a posedge).
    // mode: 0 ready held high, 1 ready pattern 1,0,0,1,0,1, 2 random ready.
    // poke: extra start pulses mid-burst and in the done cycle.
    task automatic run_burst(input string name, input int sa, input int len,
                             input int mode, input bit poke);
        int exp_len;
        int issued;
        int recv;
        int captured;
        int popped;
        int occ;
        int exp_addr;
        bit finished;
        bit stalled;
        bit full_nopop;
        bit rdy;
        bit pop;
        bit exp_last;
        logic [5:0] pat;
        logic [DATA_W-1:0] held_data;
        logic held_last;

        pat = 6'b101001;
        if (sa >= DEPTH) exp_len = 0;
        else exp_len = (len < DEPTH - sa) ? len : DEPTH - sa;

        issued = 0; recv = 0; captured = 0; popped = 0;
        finished = 0; stalled = 0; full_nopop = 0;
        held_data = '0; held_last = 1'b0;

        start      = 1'b1;
        start_addr = ADDR_W'(sa);
        length     = (ADDR_W+1)'(len);
        w_if.ready = 1'b1;

        for (int c = 1; c <= 300 && !finished; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (poke && c == 3) begin
                start      = 1'b1;
                start_addr = ADDR_W'((sa + 9) % DEPTH);
                length     = (ADDR_W+1)'(3);
            end

            occ = captured - popped;
            tests_run++;
            if (w_if.valid !== (occ > 0)) begin
                tests_failed++;
                $display("FAIL %s valid c=%0d: got %0b expected %0b", name, c, w_if.valid, occ > 0);
            end
            tests_run++;
            if (occ > 2) begin
                tests_failed++;
                $display("FAIL %s occupancy c=%0d: got %0d expected <=2", name, c, occ);
            end
            tests_run++;
            if (bram_we !== 1'b0 || bram_di !== '0) begin
                tests_failed++;
                $display("FAIL %s bram_write c=%0d: got we=%0b di=%0h expected 0/0", name, c, bram_we, bram_di);
            end
            if (c == 1) begin
                tests_run++;
                if (bram_en !== (exp_len > 0)) begin
                    tests_failed++;
                    $display("FAIL %s first_en: got %0b expected %0b", name, bram_en, exp_len > 0);
                end
                if (exp_len > 0) begin
                    tests_run++;
                    if (bram_addr !== ADDR_W'(sa)) begin
                        tests_failed++;
                        $display("FAIL %s first_addr: got %0d expected %0d", name, bram_addr, sa);
                    end
                end
            end
            if (full_nopop) begin
                tests_run++;
                if (bram_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s stall_en c=%0d: got %0b expected 0", name, c, bram_en);
                end
            end
            if (bram_en === 1'b1) begin
                exp_addr = sa + issued;
                tests_run++;
                if (issued >= exp_len || bram_addr !== ADDR_W'(exp_addr) || exp_addr >= DEPTH) begin
                    tests_failed++;
                    $display("FAIL %s read_addr c=%0d: got %0d expected %0d (read %0d of %0d)",
                             name, c, bram_addr, exp_addr, issued + 1, exp_len);
                end
                issued++;
            end
            if (stalled) begin
                tests_run++;
                if (w_if.valid !== 1'b1 || w_if.data !== held_data || w_if.last !== held_last) begin
                    tests_failed++;
                    $display("FAIL %s stall_hold c=%0d: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                             name, c, w_if.valid, w_if.data, w_if.last, held_data, held_last);
                end
            end

            if (done === 1'b1) begin
                tests_run++;
                if (recv != exp_len || w_if.valid !== 1'b0 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s done_state c=%0d: got words=%0d valid=%0b busy=%0b expected %0d/0/0",
                             name, c, recv, w_if.valid, busy, exp_len);
                end
                if (mode == 0) begin
                    tests_run++;
                    if (c != exp_len + 2) begin
                        tests_failed++;
                        $display("FAIL %s done_cycle: got %0d expected %0d", name, c, exp_len + 2);
                    end
                end
                finished = 1;
                if (poke) begin
                    start      = 1'b1;
                    start_addr = ADDR_W'(0);
                    length     = (ADDR_W+1)'(4);
                end
            end else begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s busy c=%0d: got %0b expected 1", name, c, busy);
                end
            end

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[c % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            w_if.ready = rdy;
            pop = (w_if.valid === 1'b1) && rdy;
            if (pop) begin
                tests_run++;
                if (recv >= exp_len) begin
                    tests_failed++;
                    $display("FAIL %s extra_word: got %0h expected no word", name, w_if.data);
                end else begin
                    exp_last = (recv == exp_len - 1);
                    if (w_if.data !== mem[sa + recv] || w_if.last !== exp_last) begin
                        tests_failed++;
                        $display("FAIL %s word%0d: got d=%0h l=%0b expected d=%0h l=%0b",
                                 name, recv, w_if.data, w_if.last, mem[sa + recv], exp_last);
                    end
                end
                recv++;
            end
            stalled    = (w_if.valid === 1'b1) && !rdy;
            held_data  = w_if.data;
            held_last  = w_if.last;
            full_nopop = (occ == 2) && !pop;
            if (bram_en === 1'b1) captured++;
            if (pop) popped++;
        end

        if (!finished) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s timeout: got no done expected done after %0d words", name, exp_len);
        end

        // Cycle after done: done is a single pulse and a start presented in
        // the done cycle must not launch anything.
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || bram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after_done: got done=%0b busy=%0b en=%0b expected 0/0/0", name, done, busy, bram_en);
        end
        $display("[TB] burst %s sa=%0d len=%0d -> %0d words", name, sa, len, recv);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        w_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || bram_en !== 1'b0 || bram_addr !== '0 ||
            w_if.valid !== 1'b0 || w_if.last !== 1'b0 || w_if.data !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%0b done=%0b en=%0b addr=%0d v=%0b l=%0b d=%0h expected all 0",
                     busy, done, bram_en, bram_addr, w_if.valid, w_if.last, w_if.data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_full_burst();
        run_burst("full", 0, 28, 0, 1'b0);
    endtask

    task automatic test_clamp();
        run_burst("clamp", 20, 16, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_burst("backpressure", 3, 6, 1, 1'b0);
    endtask

    task automatic test_zero_length();
        run_burst("len_zero", 5, 0, 0, 1'b0);
        run_burst("addr_oob", 30, 10, 0, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_burst("mid_start", 4, 10, 0, 1'b1);
        run_burst("mid_start_bp", 11, 12, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            run_burst("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 40)), 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        start      = 1'b1;
        start_addr = ADDR_W'(2);
        length     = (ADDR_W+1)'(20);
        w_if.ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (bram_en !== 1'b1 || busy !== 1'b1 || w_if.valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_active: got en=%0b busy=%0b v=%0b expected 1/1/1", bram_en, busy, w_if.valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bram_en !== 1'b0 || w_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got en=%0b v=%0b busy=%0b done=%0b expected 0/0/0/0",
                     bram_en, w_if.valid, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || w_if.valid !== 1'b0 || bram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got busy=%0b v=%0b en=%0b expected 0/0/0", busy, w_if.valid, bram_en);
        end
        $display("[TB] reset mid-burst checked");
        run_burst("post_reset", 7, 5, 2, 1'b0);
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_full_burst();
        fill_mem();
        test_clamp();
        test_backpressure();
        test_zero_length();
        fill_mem();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
